mul_arbiter: RTL and testbench

Round-robin scheduler that shares one shift-and-add multiplier (start/finish pulse interface) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block issues one operation at a time to the multiplier, waits for completion and returns the product tagged with the requester index. It sits between the requesting datapaths and the single multiplier instance.

---
 rtl/mul_arbiter_if.sv | 33 +++
 rtl/mul_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: requester, response and multiplier-side signals of mul_arbiter.
// slave is the arbiter's own view; master is the view of the surrounding datapaths and multiplier.
interface mul_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 2 * WIDTH,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [OUT_WIDTH-1:0]     rsp_o;
  logic                     rsp_err;
  logic                     mul_in_valid;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [OUT_WIDTH-1:0]     mul_o;
  logic                     mul_out_valid;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_o, mul_out_valid,
    output req_ready, rsp_valid, rsp_id, rsp_o, rsp_err, mul_in_valid, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_o, mul_out_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_o, rsp_err, mul_in_valid, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin scheduler sharing one start/finish multiplier among NUM_REQ requesters.
// Define MUL_ARB_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT cycles, reports rsp_err).
module mul_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 2 * WIDTH,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input logic          clk,
  input logic          rst_n,
  mul_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mul_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 mul_in_valid_q, mul_in_valid_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0] rsp_o_q, rsp_o_d;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W:0]   cand;
  logic            accept;

  // Search upward from ptr; cand < 2*NUM_REQ so one conditional subtract wraps it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[ID_W-1:0];
      end
    end
  end

  assign accept        = (state_q == StIdle) && gnt_found;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    id_d           = id_q;
    a_d            = a_q;
    b_d            = b_q;
    mul_in_valid_d = 1'b0;
    rsp_valid_d    = rsp_valid_q;
    rsp_o_d        = rsp_o_q;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    rsp_err_d      = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d        = StIssue;
          id_d           = gnt_id;
          ptr_d          = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          a_d            = bus.req_a[gnt_id*WIDTH +: WIDTH];
          b_d            = bus.req_b[gnt_id*WIDTH +: WIDTH];
          mul_in_valid_d = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // A completion in the expiry cycle still wins over the watchdog.
        if (bus.mul_out_valid) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_o_d     = bus.mul_o;
`ifdef MUL_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_o_d     = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + CntW'(1);
`endif
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      id_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      mul_in_valid_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_o_q        <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      id_q           <= id_d;
      a_q            <= a_d;
      b_q            <= b_d;
      mul_in_valid_q <= mul_in_valid_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_o_q        <= rsp_o_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      rsp_err_q      <= rsp_err_d;
`endif
    end
  end

  assign bus.mul_in_valid = mul_in_valid_q;
  assign bus.mul_a        = a_q;
  assign bus.mul_b        = b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_o        = rsp_o_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign bus.rsp_err      = rsp_err_q;
`else
  assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed and random stimulus for mul_arbiter against a transaction-level
// round-robin model with a bench-side multiplier of programmable latency.
module tb_mul_arbiter;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned OUT_WIDTH = 16;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned ID_W      = 2;

  logic clk;
  logic rst_n;

  mul_arbiter_if #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .ID_W     (ID_W)
  ) bus ();

  mul_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .TIMEOUT  (TIMEOUT),
    .ID_W     (ID_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Transaction model: phase 0 = free, 1 = operation outstanding, 2 = response offered.
  int               phase;
  int               mptr;
  logic             m_issue;
  int               wcnt;
  int               m_id;
  logic [7:0]       m_a, m_b;
  logic             m_rsp_valid;
  int               m_rsp_id;
  logic [15:0]      m_rsp_o;
  logic             m_rsp_err;
  logic [NUM_REQ-1:0] vld;
  logic [7:0]       op_a [NUM_REQ];
  logic [7:0]       op_b [NUM_REQ];
  int               exp_prod[$];
  int               log_id[$];
  int               log_o[$];
  int               log_err[$];
  int               grants[$];
  int               dut_pulses;
  logic [7:0]       last_pa, last_pb;

  // Bench-side multiplier.
  int               mul_cnt;
  int               mul_lat;
  logic             mul_hang;
  logic             spur;
  logic [15:0]      mul_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] exp_ready();
    logic [NUM_REQ-1:0] r;
    int i;
    r = '0;
    if (phase != 0) return r;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (mptr + k) % NUM_REQ;
      if (vld[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic drive_reqs();
    bus.req_valid = vld;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    vld[i]  = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    logic [NUM_REQ-1:0] er;
    logic issue_now;
    logic mov;
    int   p;
    drive_reqs();
    #1;
    er = exp_ready();
    chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_rsp_id));
      chk("rsp_o", 32'(bus.rsp_o), 32'(m_rsp_o));
      chk("rsp_err", 32'(bus.rsp_err), 32'(m_rsp_err));
    end
    chk("mul_in_valid", 32'(bus.mul_in_valid), 32'(m_issue));
    if (phase == 1) begin
      chk("mul_a", 32'(bus.mul_a), 32'(m_a));
      chk("mul_b", 32'(bus.mul_b), 32'(m_b));
    end
    if (bus.mul_in_valid === 1'b1) begin
      dut_pulses++;
      last_pa = bus.mul_a;
      last_pb = bus.mul_b;
    end
    mov = bus.mul_out_valid;
    if (m_rsp_valid && bus.rsp_ready) begin
      log_id.push_back(m_rsp_id);
      log_o.push_back(int'(bus.rsp_o));
      log_err.push_back(int'(m_rsp_err));
      if (exp_prod.size() > 0) begin
        p = exp_prod.pop_front();
        if (!m_rsp_err) chk("rsp_product", 32'(bus.rsp_o), 32'(p));
      end
      phase       = 0;
      m_rsp_valid = 1'b0;
    end else if (phase == 1 && !m_issue) begin
      if (mov) begin
        m_rsp_valid = 1'b1;
        m_rsp_id    = m_id;
        m_rsp_o     = bus.mul_o;
        m_rsp_err   = 1'b0;
        phase       = 2;
`ifdef MUL_ARB_TIMEOUT_EN
      end else if (wcnt == TIMEOUT - 1) begin
        m_rsp_valid = 1'b1;
        m_rsp_id    = m_id;
        m_rsp_o     = '0;
        m_rsp_err   = 1'b1;
        phase       = 2;
`endif
      end else begin
        wcnt++;
      end
    end
    issue_now = m_issue;
    m_issue   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (er[i]) begin
        m_id = i;
        m_a  = op_a[i];
        m_b  = op_b[i];
        exp_prod.push_back(int'(op_a[i]) * int'(op_b[i]));
        mptr    = (i + 1) % NUM_REQ;
        phase   = 1;
        m_issue = 1'b1;
        wcnt    = 0;
        vld[i]  = 1'b0;
        grants.push_back(i);
      end
    end
    if (issue_now) begin
      mul_prod = 16'(m_a) * 16'(m_b);
      mul_cnt  = mul_hang ? 0 : mul_lat;
    end
    @(posedge clk);
    #1;
    drive_reqs();
    bus.mul_out_valid = spur;
    spur = 1'b0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        bus.mul_out_valid = 1'b1;
        bus.mul_o         = mul_prod;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    vld = '0;
    drive_reqs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_o", 32'(bus.rsp_o), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mul_in_valid", 32'(bus.mul_in_valid), 32'd0);
    chk("rst_mul_a", 32'(bus.mul_a), 32'd0);
    chk("rst_mul_b", 32'(bus.mul_b), 32'd0);
    phase       = 0;
    mptr        = 0;
    m_issue     = 1'b0;
    m_rsp_valid = 1'b0;
    wcnt        = 0;
    exp_prod.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int gbase;
    int pbase;
    checks = 0;
    errors = 0;
    phase = 0; mptr = 0; m_issue = 1'b0; wcnt = 0; m_id = 0;
    m_a = '0; m_b = '0; m_rsp_valid = 1'b0; m_rsp_id = 0; m_rsp_o = '0; m_rsp_err = 1'b0;
    vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    dut_pulses = 0; last_pa = '0; last_pb = '0;
    mul_cnt = 0; mul_lat = 4; mul_hang = 1'b0; spur = 1'b0; mul_prod = '0;
    rst_n = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1; bus.mul_out_valid = 1'b0; bus.mul_o = '0;
    @(negedge clk);
    do_reset();

    // Single requester, 4-cycle multiplier.
    set_req(0, 8'd3, 8'd5);
    for (int n = 0; n < 40 && log_id.size() < 1; n++) step();
    chk("t1_rsp_count", 32'(log_id.size()), 32'd1);
    chk("t1_pulses", 32'(dut_pulses), 32'd1);
    chk("t1_pulse_a", 32'(last_pa), 32'd3);
    chk("t1_pulse_b", 32'(last_pb), 32'd5);
    if (log_id.size() >= 1) begin
      chk("t1_id", 32'(log_id[0]), 32'd0);
      chk("t1_o", 32'(log_o[0]), 32'd15);
      chk("t1_err", 32'(log_err[0]), 32'd0);
    end

    // All four requesters valid right after reset.
    do_reset();
    base = log_id.size();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i + 1), 8'd2);
    for (int n = 0; n < 120 && log_id.size() < base + 4; n++) step();
    chk("t2_rsp_count", 32'(log_id.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < log_id.size()) begin
        chk("t2_order", 32'(log_id[base+k]), 32'(k));
        chk("t2_o", 32'(log_o[base+k]), 32'(2 * (k + 1)));
      end
    end

    // Grant to 2, then 0 and 3 pending: 3 must come before 0.
    base  = log_id.size();
    gbase = grants.size();
    set_req(2, 8'd7, 8'd9);
    for (int n = 0; n < 20 && grants.size() == gbase; n++) step();
    set_req(0, 8'd10, 8'd10);
    set_req(3, 8'd12, 8'd3);
    for (int n = 0; n < 120 && log_id.size() < base + 3; n++) step();
    chk("t3_rsp_count", 32'(log_id.size() - base), 32'd3);
    if (log_id.size() >= base + 3) begin
      chk("t3_first", 32'(log_id[base]), 32'd2);
      chk("t3_wrap_3", 32'(log_id[base+1]), 32'd3);
      chk("t3_wrap_0", 32'(log_id[base+2]), 32'd0);
      chk("t3_o_3", 32'(log_o[base+1]), 32'd36);
    end

    // Back-pressure in RESP with a spurious completion and a pending requester.
    base  = log_id.size();
    bus.rsp_ready = 1'b0;
    set_req(1, 8'd11, 8'd13);
    for (int n = 0; n < 30 && !m_rsp_valid; n++) step();
    chk("t4_in_resp", 32'(bus.rsp_valid), 32'd1);
    gbase = grants.size();
    pbase = dut_pulses;
    set_req(3, 8'd4, 8'd4);
    for (int n = 0; n < 5; n++) begin
      if (n == 2) spur = 1'b1;
      step();
    end
    chk("t4_no_grant", 32'(grants.size() - gbase), 32'd0);
    chk("t4_no_pulse", 32'(dut_pulses - pbase), 32'd0);
    chk("t4_held_o", 32'(bus.rsp_o), 32'd143);
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 60 && log_id.size() < base + 2; n++) step();
    chk("t4_rsp_count", 32'(log_id.size() - base), 32'd2);
    if (log_id.size() >= base + 2) begin
      chk("t4_id_1", 32'(log_id[base]), 32'd1);
      chk("t4_o_1", 32'(log_o[base]), 32'd143);
      chk("t4_id_3", 32'(log_id[base+1]), 32'd3);
      chk("t4_o_3", 32'(log_o[base+1]), 32'd16);
    end

    // Reset during WAIT followed by a late completion.
    mul_lat = 10;
    set_req(1, 8'd6, 8'd7);
    for (int n = 0; n < 20 && !(phase == 1 && !m_issue); n++) step();
    step();
    step();
    do_reset();
    base  = log_id.size();
    pbase = dut_pulses;
    for (int n = 0; n < 20 && mul_cnt != 0; n++) step();
    for (int n = 0; n < 3; n++) step();
    chk("t5_late_drained", 32'(mul_cnt), 32'd0);
    chk("t5_no_rsp", 32'(log_id.size() - base), 32'd0);
    chk("t5_no_pulse", 32'(dut_pulses - pbase), 32'd0);
    mul_lat = 2;
    set_req(1, 8'd2, 8'd3);
    set_req(0, 8'd5, 8'd6);
    for (int n = 0; n < 60 && log_id.size() < base + 2; n++) step();
    chk("t5_rsp_count", 32'(log_id.size() - base), 32'd2);
    if (log_id.size() >= base + 2) begin
      chk("t5_first_id0", 32'(log_id[base]), 32'd0);
      chk("t5_o0", 32'(log_o[base]), 32'd30);
      chk("t5_then_id1", 32'(log_id[base+1]), 32'd1);
    end

`ifdef MUL_ARB_TIMEOUT_EN
    // Multiplier never completes: watchdog answers with an error.
    base     = log_id.size();
    mul_hang = 1'b1;
    set_req(2, 8'd5, 8'd5);
    for (int n = 0; n < 40 && log_id.size() < base + 1; n++) step();
    chk("t6_rsp_count", 32'(log_id.size() - base), 32'd1);
    if (log_id.size() >= base + 1) begin
      chk("t6_id", 32'(log_id[base]), 32'd2);
      chk("t6_err", 32'(log_err[base]), 32'd1);
      chk("t6_o", 32'(log_o[base]), 32'd0);
    end
    mul_hang = 1'b0;
`endif

    // Random traffic, latency and back-pressure.
    base = log_id.size();
    for (int n = 0; n < 600; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      mul_lat       = int'($urandom_range(1, 6));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vld[i] && $urandom_range(0, 4) == 0) set_req(i, 8'($urandom), 8'($urandom));
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 400 && (vld != '0 || phase != 0); n++) step();
    chk("rand_drained", 32'(phase == 0 && vld == '0), 32'd1);
    chk("rand_progress", 32'(log_id.size() - base > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
